// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//
// Drives the register file's single write port from two writeback sources:
//   - the in-order pipeline writeback (never stalled, always wins), and
//   - the multiply/divide unit (MDU), whose results are queued in a small FIFO
//     and drained whenever the pipeline leaves the write port idle.
// Also reports, per decode source register, whether a write to it is still
// queued or sitting in the output register, so decode can stall on it.
//
// Optional feature macro: WB_MDU_BYPASS_EN
//   When defined, an MDU result that arrives while the FIFO is empty and the
//   pipeline is not writing is loaded straight into the output register
//   (1-cycle latency). When undefined, every MDU result goes through the FIFO.
//
// Parameters:
//   DEPTH   MDU result FIFO entries (power of two, >= 2)
//   ADDR_W  register address width
//   DATA_W  register data width
//
// Ports:
//   clk                    system clock, rising edge
//   reset_n                asynchronous active-low reset
//   pipe_we/rd/data        pipeline writeback request (rd == 0 means no request)
//   mdu_valid/ready/rd/data MDU result handshake
//   RegWrite/RdOrRt/WriteData  registered write port to the register file
//   rs_addr/rt_addr        decode-stage source registers
//   rs_pending/rt_pending  source has an uncommitted write held in this block
//   fifo_count             FIFO occupancy (0..DEPTH)

module wb_write_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     pipe_we,
   input  logic [ADDR_W-1:0]        pipe_rd,
   input  logic [DATA_W-1:0]        pipe_data,
   input  logic                     mdu_valid,
   output logic                     mdu_ready,
   input  logic [ADDR_W-1:0]        mdu_rd,
   input  logic [DATA_W-1:0]        mdu_data,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        RdOrRt,
   output logic [DATA_W-1:0]        WriteData,
   input  logic [ADDR_W-1:0]        rs_addr,
   input  logic [ADDR_W-1:0]        rt_addr,
   output logic                     rs_pending,
   output logic                     rt_pending,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // FIFO storage (no reset needed: validity comes from fifo_count/rd_ptr)
   logic [ADDR_W-1:0] rd_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic pipe_req;
   logic fifo_empty;
   logic mdu_xfer;
   logic mdu_keep;
   logic bypass;
   logic push;
   logic pop;

   // MDU handshake: a result transfers on any rising edge where
   // mdu_valid && mdu_ready. mdu_ready depends only on registered occupancy,
   // so it never combinationally follows mdu_valid; the MDU keeps rd/data
   // stable while valid && !ready. Results addressed to r0 still complete
   // the handshake but are dropped here.
   always_comb begin
      pipe_req   = pipe_we && (pipe_rd != '0);
      fifo_empty = (fifo_count == '0);
      mdu_ready  = (fifo_count != FULL_CNT);
      mdu_xfer   = mdu_valid && mdu_ready;
      mdu_keep   = mdu_xfer && (mdu_rd != '0);
`ifdef WB_MDU_BYPASS_EN
      bypass     = mdu_keep && fifo_empty && !pipe_req;
`else
      bypass     = 1'b0;
`endif
      push       = mdu_keep && !bypass;
      // The pipeline owns the write port whenever it has a real request.
      pop        = !pipe_req && !fifo_empty;
   end

   // Output register: pipeline first, then FIFO head, then (bypass) MDU.
   // Address/data hold when no write is issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         RegWrite  <= 1'b0;
         RdOrRt    <= '0;
         WriteData <= '0;
      end else if (pipe_req) begin
         RegWrite  <= 1'b1;
         RdOrRt    <= pipe_rd;
         WriteData <= pipe_data;
      end else if (pop) begin
         RegWrite  <= 1'b1;
         RdOrRt    <= rd_mem[rd_ptr];
         WriteData <= data_mem[rd_ptr];
      end else if (bypass) begin
         RegWrite  <= 1'b1;
         RdOrRt    <= mdu_rd;
         WriteData <= mdu_data;
      end else begin
         RegWrite  <= 1'b0;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= mdu_rd;
         data_mem[wr_ptr] <= mdu_data;
      end
   end

   // Pending flags: scan the occupied FIFO slots (offset from rd_ptr below
   // fifo_count) plus the write currently presented to the register file.
   logic [PTR_W-1:0] scan_idx;
   logic             rs_hit;
   logic             rt_hit;

   always_comb begin
      scan_idx = '0;
      rs_hit   = RegWrite && (RdOrRt == rs_addr);
      rt_hit   = RegWrite && (RdOrRt == rt_addr);
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr + PTR_W'(i);
         if ((PTR_W+1)'(i) < fifo_count) begin
            if (rd_mem[scan_idx] == rs_addr) rs_hit = 1'b1;
            if (rd_mem[scan_idx] == rt_addr) rt_hit = 1'b1;
         end
      end
      rs_pending = rs_hit && (rs_addr != '0);
      rt_pending = rt_hit && (rt_addr != '0);
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter (DEPTH=4, ADDR_W=5, DATA_W=32).
// A reference model keeps the MDU FIFO as a queue of {rd,data} entries and
// decides each edge which write the register file should receive; expected
// writes go into exp_q and a separate monitor pops/compares on every cycle.

module tb_wb_write_arbiter;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int W      = ADDR_W + DATA_W;
   localparam int CW     = $clog2(DEPTH) + 1;
`ifdef WB_MDU_BYPASS_EN
   localparam int MDU_LAT = 1;
`else
   localparam int MDU_LAT = 2;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              pipe_we = 1'b0;
   logic [ADDR_W-1:0] pipe_rd = '0;
   logic [DATA_W-1:0] pipe_data = '0;
   logic              mdu_valid = 1'b0;
   logic              mdu_ready;
   logic [ADDR_W-1:0] mdu_rd = '0;
   logic [DATA_W-1:0] mdu_data = '0;
   logic              RegWrite;
   logic [ADDR_W-1:0] RdOrRt;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] rs_addr = '0;
   logic [ADDR_W-1:0] rt_addr = '0;
   logic              rs_pending;
   logic              rt_pending;
   logic [CW-1:0]     fifo_count;

   wb_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .RegWrite(RegWrite), .RdOrRt(RdOrRt), .WriteData(WriteData),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_pending(rs_pending), .rt_pending(rt_pending),
      .fifo_count(fifo_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];   // writes the register file must see, in order
   logic [W-1:0] mq[$];      // model of queued MDU results
   logic [W-1:0] src_q[$];   // MDU results still to be offered
   logic              out_we_m = 1'b0;
   logic [ADDR_W-1:0] out_rd_m = '0;
   logic [ADDR_W-1:0] rs_sel = '0;
   logic [ADDR_W-1:0] rt_sel = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // A register is pending if it is the target of the write being presented
   // or of any result still waiting in the queue.
   function automatic bit model_pending(input logic [ADDR_W-1:0] a);
      if (a == '0) return 1'b0;
      if (out_we_m && out_rd_m == a) return 1'b1;
      foreach (mq[i]) if (mq[i][W-1:DATA_W] == a) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle(input bit pwe, input logic [ADDR_W-1:0] prd,
                        input logic [DATA_W-1:0] pdata, output bit acc);
      bit mv, ready_m, xfer, wrote, byp;
      logic [W-1:0] offer, wr;
      @(negedge clk);
      pipe_we   = pwe;
      pipe_rd   = prd;
      pipe_data = pdata;
      mv        = (src_q.size() != 0);
      offer     = mv ? src_q[0] : '0;
      mdu_valid = mv;
      mdu_rd    = offer[W-1:DATA_W];
      mdu_data  = offer[DATA_W-1:0];
      rs_addr   = rs_sel;
      rt_addr   = rt_sel;
      #1;
      ready_m = (mq.size() != DEPTH);
      check("mdu_ready", 64'(mdu_ready), 64'(ready_m));
      check("fifo_count", 64'(fifo_count), 64'(mq.size()));
      check("rs_pending", 64'(rs_pending), 64'(model_pending(rs_sel)));
      check("rt_pending", 64'(rt_pending), 64'(model_pending(rt_sel)));
      @(posedge clk);
      xfer  = mv && ready_m;
      wrote = 1'b0;
      byp   = 1'b0;
      wr    = '0;
      if (pwe && prd != '0) begin
         wr = {prd, pdata};
         wrote = 1'b1;
      end else if (mq.size() != 0) begin
         wr = mq.pop_front();
         wrote = 1'b1;
      end
`ifdef WB_MDU_BYPASS_EN
      else if (xfer && offer[W-1:DATA_W] != '0) begin
         wr = offer;
         wrote = 1'b1;
         byp = 1'b1;
      end
`endif
      if (xfer) begin
         void'(src_q.pop_front());
         if (offer[W-1:DATA_W] != '0 && !byp) mq.push_back(offer);
      end
      if (wrote) begin
         exp_q.push_back(wr);
         out_rd_m = wr[W-1:DATA_W];
      end
      out_we_m = wrote;
      acc = xfer;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, $urandom, a);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((src_q.size() != 0 || mq.size() != 0 || out_we_m) && k < 40) begin
         idle(1);
         k++;
      end
      idle(1);
      check(name, 64'(src_q.size() + mq.size()), 64'd0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n) begin
            total++;
            if (RegWrite) begin
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write at %0t",
                           RdOrRt, WriteData, $time);
               end else begin
                  e = exp_q.pop_front();
                  if ({RdOrRt, WriteData} !== e) begin
                     bad++;
                     $display("FAIL write: got rd=%0d data=%0h expected rd=%0d data=%0h at %0t",
                              RdOrRt, WriteData, e[W-1:DATA_W], e[DATA_W-1:0], $time);
                  end
               end
            end else if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               bad++;
               $display("FAIL missing_write: got none expected rd=%0d data=%0h at %0t",
                        e[W-1:DATA_W], e[DATA_W-1:0], $time);
            end
         end
      end
   end

   // ---------------- reset helpers ----------------
   task automatic reset_checks(input string tag);
      check({tag, "_RegWrite"}, 64'(RegWrite), 64'd0);
      check({tag, "_RdOrRt"}, 64'(RdOrRt), 64'd0);
      check({tag, "_WriteData"}, 64'(WriteData), 64'd0);
      check({tag, "_fifo_count"}, 64'(fifo_count), 64'd0);
      check({tag, "_mdu_ready"}, 64'(mdu_ready), 64'd1);
   endtask

   task automatic clear_model();
      exp_q.delete();
      mq.delete();
      src_q.delete();
      out_we_m  = 1'b0;
      pipe_we   = 1'b0;
      mdu_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit a;
      int acc_cnt, lat;

      // initial reset
      #2 reset_n = 1'b0;
      #1 reset_checks("rst_init");
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      // single pipe write
      cycle(1'b1, 5'd8, 32'h1234, a);
      idle(2);

      // writes to r0 from both sources are ignored
      src_q.push_back({5'd0, 32'hDEAD});
      cycle(1'b1, 5'd0, 32'hBEEF, a);
      cycle(1'b1, 5'd0, 32'hBEEF, a);
      idle(3);

      // starve and fill: 6 pipe cycles while MDU offers r9..r13
      rt_sel = 5'd10;
      rs_sel = 5'd9;
      for (int r = 9; r <= 13; r++) src_q.push_back({5'(r), $urandom});
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 5'($urandom_range(14, 31)), $urandom, a);
         if (a) acc_cnt++;
      end
      check("starve_accepts", 64'(acc_cnt), 64'd4);
      drain("starve_drain");
      idle(1);

      // isolated MDU result latency
      rs_sel = 5'd5;
      src_q.push_back({5'd5, 32'hCAFE});
      a = 1'b0;
      for (int i = 0; i < 5 && !a; i++) cycle(1'b0, '0, '0, a);
      #1;
      lat = 1;
      while (!RegWrite && lat < 6) begin
         idle(1);
         #1;
         lat++;
      end
      check("mdu_latency", 64'(lat), 64'(MDU_LAT));
      idle(2);

      // back-to-back MDU results across pointer wrap
      for (int i = 0; i < 3 * DEPTH; i++) src_q.push_back({5'($urandom_range(1, 31)), $urandom});
      drain("wrap_drain");

      // reset in the middle of traffic
      for (int i = 0; i < 3; i++) src_q.push_back({5'($urandom_range(1, 31)), $urandom});
      for (int i = 0; i < 3; i++) cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, a);
      #3 reset_n = 1'b0;
      #1 reset_checks("rst_mid");
      clear_model();
      @(negedge clk) reset_n = 1'b1;
      idle(3);

      // randomized mixed traffic on a small register range
      for (int i = 0; i < 300; i++) begin
         rs_sel = 5'($urandom_range(0, 7));
         rt_sel = 5'($urandom_range(0, 7));
         if (src_q.size() < 6 && $urandom_range(0, 2) == 0)
            src_q.push_back({5'($urandom_range(0, 7)), $urandom});
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, a);
      end
      drain("random_drain");
      idle(2);
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

- Drives the register file's single write port (`RegWrite`, `RdOrRt`, `WriteData`) from two writeback sources:
  - the in-order pipeline writeback, which cannot be stalled and always has priority;
  - a long-latency multiply/divide unit (MDU), which uses a valid/ready handshake and is buffered in a small FIFO.
- Exports per-register pending flags so the hazard unit can stall decode on reads of queued destinations.

## Interface
Parameters:
- `DEPTH`, 4: MDU result FIFO entries (power of two, ≥2).
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pipe_we`  in  1  pipeline writeback request this cycle.
- `pipe_rd`  in  ADDR_W  pipeline destination register.
- `pipe_data`  in  DATA_W  pipeline write data.
- `mdu_valid`  in  1  MDU result offered.
- `mdu_ready`  out  1  arbiter can accept an MDU result.
- `mdu_rd`  in  ADDR_W  MDU destination register.
- `mdu_data`  in  DATA_W  MDU result.
- `RegWrite`  out  1  registered write enable to the register file.
- `RdOrRt`  out  ADDR_W  registered write address.
- `WriteData`  out  DATA_W  registered write data.
- `rs_addr`, `rt_addr`  in  ADDR_W  decode-stage source registers.
- `rs_pending`, `rt_pending`  out  1  source has an uncommitted write in this block.
- `fifo_count`  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- **Output register.** Reloads every cycle from the first match, in priority order:
  1. `pipe_we && pipe_rd != 0`: write `pipe_rd`/`pipe_data`.
  2. FIFO non-empty: pop the head and write its entry.
  3. Otherwise: `RegWrite` = 0. `RdOrRt` and `WriteData` hold their values.
- **Register 0.** A pipe write to r0 is treated as no request. An MDU handshake with `mdu_rd == 0` completes but is discarded: it is not enqueued and causes no write.
- **Handshake.**
  - `mdu_ready = (fifo_count != DEPTH)`, combinational from registered state only.
  - An MDU transfer occurs on an edge where `mdu_valid && mdu_ready`.
  - The MDU holds `rd`/`data` stable while `valid && !ready`.
- **Full FIFO.** No push is accepted while full, even on a cycle that pops.
- **Push and pop together.** When not full, a push and a pop on the same edge leave `fifo_count` unchanged. Pointers wrap modulo DEPTH.
- **Starvation.** Continuous pipe writes starve the FIFO. The MDU sees `mdu_ready` = 0 once the FIFO is full; no data is lost.
- **Ordering.** Order is preserved within each source, not across sources. WAW between sources is prevented by the hazard unit using the pending flags.
- **Pending flags.** `rs_pending` = 1 iff `rs_addr != 0` and either:
  - a valid FIFO entry has `rd == rs_addr`, or
  - `RegWrite && RdOrRt == rs_addr`.
  
  `rt_pending` is identical for `rt_addr`. Both are combinational.

## Timing
- **Reset.** While `reset_n` = 0, asynchronously: `RegWrite` = 0, `RdOrRt` = 0, `WriteData` = 0, `fifo_count` = 0, FIFO pointers = 0, so `mdu_ready` = 1.
- **Reset mid-operation.** All queued entries and any in-flight output write are dropped; no register-file write occurs for them.
- **Pipe latency.** 1 cycle: a request at edge N has `RegWrite` high during cycle N+1. The register file commits it at edge N+1.
- **MDU latency (FIFO path).** Enqueue at edge N; earliest pop at edge N+1, so `RegWrite` is high during cycle N+2. Each concurrent pipe write adds 1 cycle.
- **Throughput.** 1 register-file write per cycle.
- **Pending window.** A flag deasserts in the cycle after the write's `RegWrite` cycle.

## Configuration
- **Macro:** `WB_MDU_BYPASS_EN`.
- **Defined:** on a transfer edge where the FIFO is empty and no valid pipe write is present, the MDU result loads the output register directly. `RegWrite` is high in the next cycle (1-cycle latency) and `fifo_count` stays 0.
- **Undefined:** every MDU result passes through the FIFO, giving a minimum latency of 2 cycles. Pending-flag semantics are unchanged in both builds.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-cycle → `RegWrite` = 0, `fifo_count` = 0 and `mdu_ready` = 1 immediately, without waiting for a clock edge.
- **Pipe write:** `pipe_we` = 1, `pipe_rd` = 8, `pipe_data` = 0x1234 at edge N → `RegWrite` = 1, `RdOrRt` = 8, `WriteData` = 0x1234 in cycle N+1.
- **r0 writes:** `pipe_rd` = 0, or an MDU result to r0 → `RegWrite` never asserts and `fifo_count` stays 0.
- **Starve and fill:**
  - Stimulus: `pipe_we` held 1 for 6 cycles while the MDU offers 5 results to r9..r13.
  - During the pipe burst: `mdu_ready` drops after 4 accepts and `fifo_count` = 4; `rt_addr` = 10 gives `rt_pending` = 1.
  - After the pipe burst ends: r9..r13 are written in order on consecutive cycles, and `rt_pending` = 0 after r10 commits.
- **Latency and wrap:**
  - Bypass macro undefined: an isolated MDU result (rd = 5, data = 0xCAFE) writes 2 cycles after transfer.
  - Bypass macro defined: the same result writes 1 cycle after transfer.
  - 3×DEPTH back-to-back MDU results with no pipe traffic arrive in order, with no loss across pointer wrap.
